id_ex_operand_stage: RTL and testbench
======================================

# id_ex_operand_stage

ID/EX pipeline stage of the MIPS core that sits directly upstream of the ALU and supplies its `srcA`, `srcB` and `ALUCtrl` inputs. It registers decoded operands and control, resolves RAW hazards via forwarding from EX/MEM and MEM/WB, and detects load-use hazards. It inserts bubbles and asserts a stall toward IF/ID. It also supports flush on taken branch and hold from a memory wait.

## Interface
- `RW`, 5: register index width.
- `DW`, 32: datapath width.

Ports, clock and reset first:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `id_valid`  in  1  decode slot holds a real instruction.
- `id_rs`, `id_rt`, `id_rd`  in  RW  source and destination indices. `id_rd` is already muxed rt/rd by decode.
- `id_use_rs`, `id_use_rt`  in  1  instruction reads rs / rt.
- `id_rs_data`, `id_rt_data`  in  DW  register-file read data. The register file is write-through, so MEM/WB writes in the same cycle are visible.
- `id_imm`  in  DW  sign/zero-extended immediate.
- `id_alu_src_imm`  in  1  when set, srcB selects the immediate.
- `id_alu_ctrl`  in  4  ALU op, same encoding as the ALU.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg`  in  1  control bits.
- `exmem_reg_write`  in  1  write-enable of the EX/MEM instruction.
- `exmem_rd`  in  RW  destination of the EX/MEM instruction.
- `exmem_result`  in  DW  result of the EX/MEM instruction.
- `memwb_reg_write`  in  1  write-enable of the MEM/WB instruction.
- `memwb_rd`  in  RW  destination of the MEM/WB instruction.
- `memwb_result`  in  DW  result of the MEM/WB instruction.
- `flush_i`  in  1  squash the decode slot (taken branch).
- `hold_i`  in  1  freeze the stage (downstream memory wait).
- `stall_o`  out  1  IF/ID must hold its contents this cycle.
- `srcA`, `srcB`  out  DW  ALU operands.
- `ALUCtrl`  out  4  ALU op.
- `store_data`  out  DW  forwarded rt value, for `sw`.
- `ex_valid`, `ex_rd`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg`  out  registered control passed to EX/MEM.

## Operation
- Registered state holds: valid, rs, rt, rd, use_rs/use_rt, rs_data, rt_data, imm, alu_src_imm, alu_ctrl, and the four control bits.
- Update priority at each edge:
  1. `flush_i`: load a bubble.
  2. `hold_i`: retain all contents.
  3. Load-use stall: load a bubble.
  4. Otherwise: load the decode slot.
- Bubble: valid = 0, every control bit = 0, ALUCtrl = 0000 (add). Data fields are don't-care but are driven to 0.
- Load-use hazard:
  - Condition: `ex_valid & ex_mem_read & ex_rd != 0 & id_valid`, and either (`id_use_rs & id_rs == ex_rd`) or (`id_use_rt & id_rt == ex_rd`).
  - `stall_o` = hazard `& !flush_i`.
  - `stall_o` is also asserted whenever `hold_i & !flush_i`.
- Forwarding, combinational and applied on the registered operands, separately for rs and rt:
  - EX/MEM match (`exmem_reg_write`, `exmem_rd != 0`, equal index) selects `exmem_result`.
  - Otherwise a MEM/WB match selects `memwb_result`.
  - Otherwise the registered data is used.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Operand outputs: `srcA` = forwarded rs. `srcB` = `alu_src_imm ? imm : forwarded rt`. `store_data` = forwarded rt, always.
- Outputs are driven for bubbles as well. Downstream qualifies them with `ex_valid`.

## Timing
- Reset (asynchronous): all registered state clears to bubble values. Consequently `ex_valid` = 0, `srcA` = `srcB` = `store_data` = 0, `ALUCtrl` = 0, and `stall_o` = 0. Forwarding inputs still affect the operand outputs combinationally only if the stored index matches and is non-zero, which cannot happen after reset.
- Latency: decode to `srcA`/`srcB`/`ALUCtrl` takes one cycle.
- `stall_o` is combinational in the same cycle as the hazard.
- A load-use stall lasts exactly one cycle. After the bubble enters, the load is in EX/MEM and `ex_mem_read` of the bubble is 0.
- `flush_i` together with a stall: the result is a bubble and `stall_o` = 0.
- `flush_i` together with `hold_i`: flush wins.
- Reset asserted mid-stall: contents clear immediately and `stall_o` drops in the same cycle.

## Configuration
- `ID_EX_FWD_EN` defined: forwarding as described above.
- `ID_EX_FWD_EN` undefined:
  - Forwarding muxes are removed and operands come straight from registered data.
  - The hazard condition is extended: it also fires on a used, non-zero source matching `ex_rd` (with `ex_reg_write`) or `exmem_rd` (with `exmem_reg_write`), regardless of `mem_read`.
  - MEM/WB is covered by the write-through register file.

## Structure
- `mips_pkg` holds:
  - the `alu_ctrl_t` enum: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 sll, 0101 srl, 0110 slt, 0111 beq, 1000 bne;
  - the `ex_ctrl_t` packed struct (reg_write, mem_read, mem_write, mem_to_reg);
  - the `BUBBLE_CTRL` constant.
- Sub-module `fwd_sel`, instantiated twice: inputs are index, registered data, and the EX/MEM and MEM/WB tuples; output is the forwarded value.

## Test plan
- Reset: assert `rst` mid-cycle -> `ex_valid` = 0, `stall_o` = 0, and `srcA` = `srcB` = 0 immediately.
- EX/MEM forward: `add $3` in EX/MEM with `exmem_result` = 0x0000_0010, next instruction reads `$3` with stale data 0x5 -> `srcA` = 0x10.
- Dual match: both EX/MEM (0xAA) and MEM/WB (0xBB) target `$4` -> `srcB` = 0xAA. With rd = 0 in both -> `srcB` = stored value.
- Load-use: `lw $2` in ID/EX, decode `add $5,$2,$1` -> `stall_o` = 1 for 1 cycle, one bubble inserted, then `srcA` = the `memwb_result` load value.
- Flush plus hazard: load-use condition and `flush_i` = 1 together -> `stall_o` = 0 and next `ex_valid` = 0.
- Hold: `hold_i` = 1 for 3 cycles -> all outputs stable and `stall_o` = 1. Release -> the decode slot loads on the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core types: ALU op encoding, EX/MEM control bundle and the ID/EX payload.
package mips_pkg;

  localparam int unsigned RW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;

  typedef enum logic [AW-1:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_SLL = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SLT = 4'b0110,
    ALU_BEQ = 4'b0111,
    ALU_BNE = 4'b1000
  } alu_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ex_ctrl_t;

  localparam ex_ctrl_t BUBBLE_CTRL = '0;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic          use_rs;
    logic          use_rt;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic          alu_src_imm;
    alu_ctrl_t     alu_ctrl;
    ex_ctrl_t      ctrl;
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '0;

  // True when a used, non-zero source register matches the destination dst.
  function automatic logic src_hit(input logic use_rs, input logic [RW-1:0] rs,
                                   input logic use_rt, input logic [RW-1:0] rt,
                                   input logic [RW-1:0] dst);
    return (dst != '0) && ((use_rs && (rs == dst)) || (use_rt && (rt == dst)));
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_sel.sv
// Per-operand bypass mux (EX/MEM over MEM/WB, never $0); pass-through unless ID_EX_FWD_EN.
module fwd_sel
  import mips_pkg::*;
(
  input  logic [RW-1:0] idx,
  input  logic [DW-1:0] reg_data,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] fwd_data
);

`ifdef ID_EX_FWD_EN
  always_comb begin
    fwd_data = reg_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == idx))
      fwd_data = exmem_result;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == idx))
      fwd_data = memwb_result;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{idx, exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result};
  assign fwd_data   = reg_data;
`endif

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register with operand bypass and load-use stall; ID_EX_FWD_EN enables forwarding,
// otherwise any pending EX or EX/MEM producer of a used source stalls decode.
module id_ex_operand_stage
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_alu_src_imm,
  input  logic [AW-1:0] id_alu_ctrl,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  input  logic          flush_i,
  input  logic          hold_i,
  output logic          stall_o,
  output logic [DW-1:0] srcA,
  output logic [DW-1:0] srcB,
  output logic [AW-1:0] ALUCtrl,
  output logic [DW-1:0] store_data,
  output logic          ex_valid,
  output logic [RW-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg
);

  idex_t         q;
  idex_t         slot;
  logic          hazard;
  logic [DW-1:0] rs_fwd;
  logic [DW-1:0] rt_fwd;

  always_comb begin
    slot             = IDEX_BUBBLE;
    slot.valid       = id_valid;
    slot.rs          = id_rs;
    slot.rt          = id_rt;
    slot.rd          = id_rd;
    slot.use_rs      = id_use_rs;
    slot.use_rt      = id_use_rt;
    slot.rs_data     = id_rs_data;
    slot.rt_data     = id_rt_data;
    slot.imm         = id_imm;
    slot.alu_src_imm = id_alu_src_imm;
    slot.alu_ctrl    = alu_ctrl_t'(id_alu_ctrl);
    slot.ctrl        = '{reg_write: id_reg_write, mem_read: id_mem_read,
                         mem_write: id_mem_write, mem_to_reg: id_mem_to_reg};
  end

  // Without bypassing, any in-flight producer of a used source must drain first.
  always_comb begin
    hazard = 1'b0;
    if (id_valid) begin
      if (q.valid && q.ctrl.mem_read)
        hazard = src_hit(id_use_rs, id_rs, id_use_rt, id_rt, q.rd);
`ifndef ID_EX_FWD_EN
      if (q.valid && q.ctrl.reg_write)
        hazard = hazard | src_hit(id_use_rs, id_rs, id_use_rt, id_rt, q.rd);
      if (exmem_reg_write)
        hazard = hazard | src_hit(id_use_rs, id_rs, id_use_rt, id_rt, exmem_rd);
`endif
    end
  end

  assign stall_o = !flush_i && (hazard || hold_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= IDEX_BUBBLE;
    else if (flush_i)
      q <= IDEX_BUBBLE;
    else if (!hold_i)
      q <= hazard ? IDEX_BUBBLE : slot;
  end

  fwd_sel u_fwd_rs (
    .idx(q.rs), .reg_data(q.rs_data),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .fwd_data(rs_fwd)
  );

  fwd_sel u_fwd_rt (
    .idx(q.rt), .reg_data(q.rt_data),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .fwd_data(rt_fwd)
  );

  logic unused_regs;
  assign unused_regs = ^{q.use_rs, q.use_rt};

  assign srcA          = rs_fwd;
  assign srcB          = q.alu_src_imm ? q.imm : rt_fwd;
  assign store_data    = rt_fwd;
  assign ALUCtrl       = AW'(q.alu_ctrl);
  assign ex_valid      = q.valid;
  assign ex_rd         = q.rd;
  assign ex_reg_write  = q.ctrl.reg_write;
  assign ex_mem_read   = q.ctrl.mem_read;
  assign ex_mem_write  = q.ctrl.mem_write;
  assign ex_mem_to_reg = q.ctrl.mem_to_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage; expectations follow ID_EX_FWD_EN when defined.
module tb_id_ex_operand_stage;
  import mips_pkg::*;

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [4:0]    id_rs, id_rt, id_rd;
  logic          id_use_rs, id_use_rt;
  logic [31:0]   id_rs_data, id_rt_data, id_imm;
  logic          id_alu_src_imm;
  logic [3:0]    id_alu_ctrl;
  logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic          exmem_reg_write;
  logic [4:0]    exmem_rd;
  logic [31:0]   exmem_result;
  logic          memwb_reg_write;
  logic [4:0]    memwb_rd;
  logic [31:0]   memwb_result;
  logic          flush_i, hold_i;
  logic          stall_o;
  logic [31:0]   srcA, srcB, store_data;
  logic [3:0]    ALUCtrl;
  logic          ex_valid;
  logic [4:0]    ex_rd;
  logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_src_imm(id_alu_src_imm), .id_alu_ctrl(id_alu_ctrl),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .flush_i(flush_i), .hold_i(hold_i), .stall_o(stall_o),
    .srcA(srcA), .srcB(srcB), .ALUCtrl(ALUCtrl), .store_data(store_data),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  task automatic idle_inputs();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_use_rs = 0; id_use_rt = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alu_src_imm = 0; id_alu_ctrl = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    flush_i = 0; hold_i = 0;
  endtask

  // ctl = {reg_write, mem_read, mem_write, mem_to_reg}
  task automatic drive_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic urs, input logic urt,
                             input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                             input logic simm, input logic [3:0] alu, input logic [3:0] ctl);
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_use_rs = urs; id_use_rt = urt;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alu_src_imm = simm; id_alu_ctrl = alu;
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg} = ctl;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    n_cmp++; if (srcA !== 32'h0 || srcB !== 32'h0) begin n_err++; $display("FAIL reset_src: got %h/%h want 0/0", srcA, srcB); end
    // lw $2 into ID/EX, then a dependent add stalls; reset mid-cycle clears it
    drive_instr(5'd1, 5'd0, 5'd2, 1, 0, 32'h40, 32'h0, 32'h8, 1, 4'd0, 4'b1101);
    step();
    drive_instr(5'd2, 5'd1, 5'd5, 1, 1, 32'h5, 32'h3, 32'h0, 0, 4'd0, 4'b1000);
    #1;
    n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL reset_pre_stall: got %b want 1", stall_o); end
    n_cmp++; if (srcA !== 32'h40 || srcB !== 32'h8) begin n_err++; $display("FAIL reset_pre_src: got %h/%h want 40/8", srcA, srcB); end
    #1 rst = 1;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_mid_stall: got %b want 0", stall_o); end
    n_cmp++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0) begin n_err++; $display("FAIL reset_mid_ctrl: got %b/%b want 0/0", ex_valid, ex_mem_read); end
    n_cmp++; if (srcA !== 32'h0 || srcB !== 32'h0 || ALUCtrl !== 4'h0) begin n_err++; $display("FAIL reset_mid_ops: got %h/%h/%h want 0/0/0", srcA, srcB, ALUCtrl); end
    @(posedge clk); #1 rst = 0;
    idle_inputs();
  endtask

  task automatic test_decode();
    drive_instr(5'd6, 5'd7, 5'd9, 1, 1, 32'h7, 32'h9, 32'h0, 0, 4'd1, 4'b1000);
    step(); idle_inputs(); #1;
    n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd9 || ex_reg_write !== 1'b1) begin n_err++; $display("FAIL decode_ctrl: got v=%b rd=%0d rw=%b want 1/9/1", ex_valid, ex_rd, ex_reg_write); end
    n_cmp++; if (srcA !== 32'h7 || srcB !== 32'h9 || ALUCtrl !== 4'd1) begin n_err++; $display("FAIL decode_ops: got %h/%h/%h want 7/9/1", srcA, srcB, ALUCtrl); end
    drive_instr(5'd6, 5'd7, 5'd0, 1, 1, 32'h1000, 32'hDEAD, 32'h4, 1, 4'd0, 4'b0010);
    step(); idle_inputs(); #1;
    n_cmp++; if (srcA !== 32'h1000 || srcB !== 32'h4) begin n_err++; $display("FAIL decode_imm: got %h/%h want 1000/4", srcA, srcB); end
    n_cmp++; if (store_data !== 32'hDEAD) begin n_err++; $display("FAIL decode_store_data: got %h want dead", store_data); end
    n_cmp++; if (ex_mem_write !== 1'b1 || ex_reg_write !== 1'b0 || ex_mem_to_reg !== 1'b0) begin n_err++; $display("FAIL decode_sw_ctrl: got mw=%b rw=%b m2r=%b want 1/0/0", ex_mem_write, ex_reg_write, ex_mem_to_reg); end
  endtask

  task automatic test_exmem_fwd();
    logic [31:0] exp;
    drive_instr(5'd3, 5'd0, 5'd8, 1, 0, 32'h5, 32'h0, 32'h0, 0, 4'd0, 4'b1000);
    step(); idle_inputs();
    exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'h10;
    #1; exp = FWD ? 32'h10 : 32'h5;
    n_cmp++; if (srcA !== exp) begin n_err++; $display("FAIL exmem_fwd_srcA: got %h want %h", srcA, exp); end
    memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 32'h99;
    #1;
    n_cmp++; if (srcA !== exp) begin n_err++; $display("FAIL exmem_over_memwb_srcA: got %h want %h", srcA, exp); end
    exmem_reg_write = 0;
    #1; exp = FWD ? 32'h99 : 32'h5;
    n_cmp++; if (srcA !== exp) begin n_err++; $display("FAIL memwb_fwd_srcA: got %h want %h", srcA, exp); end
    memwb_reg_write = 0;
    #1;
    n_cmp++; if (srcA !== 32'h5) begin n_err++; $display("FAIL no_fwd_srcA: got %h want 5", srcA); end
    idle_inputs();
  endtask

  task automatic test_dual_match();
    logic [31:0] exp;
    drive_instr(5'd0, 5'd4, 5'd0, 0, 1, 32'h0, 32'h44, 32'h0, 0, 4'd2, 4'b1000);
    step(); idle_inputs();
    exmem_reg_write = 1; exmem_rd = 5'd4; exmem_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 5'd4; memwb_result = 32'hBB;
    #1; exp = FWD ? 32'hAA : 32'h44;
    n_cmp++; if (srcB !== exp || store_data !== exp) begin n_err++; $display("FAIL dual_match_srcB: got %h/%h want %h", srcB, store_data, exp); end
    idle_inputs();
    drive_instr(5'd0, 5'd0, 5'd0, 0, 1, 32'h0, 32'h77, 32'h0, 0, 4'd2, 4'b1000);
    step(); idle_inputs();
    exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 5'd0; memwb_result = 32'hBB;
    #1;
    n_cmp++; if (srcB !== 32'h77) begin n_err++; $display("FAIL reg0_no_fwd_srcB: got %h want 77", srcB); end
    idle_inputs();
  endtask

  task automatic test_load_use();
    // lw $2, 0($1) enters ID/EX
    drive_instr(5'd1, 5'd0, 5'd2, 1, 0, 32'h100, 32'h0, 32'h0, 1, 4'd0, 4'b1101);
    step();
    // add $5,$2,$1 in decode with stale $2
    drive_instr(5'd2, 5'd1, 5'd5, 1, 1, 32'h5, 32'h3, 32'h0, 0, 4'd0, 4'b1000);
    #1;
    n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL load_use_stall: got %b want 1", stall_o); end
    step();
    n_cmp++; if (ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_reg_write !== 1'b0) begin n_err++; $display("FAIL load_use_bubble: got v=%b mr=%b rw=%b want 0/0/0", ex_valid, ex_mem_read, ex_reg_write); end
    exmem_reg_write = 1; exmem_rd = 5'd2; exmem_result = 32'h100;
    #1;
`ifdef ID_EX_FWD_EN
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL load_use_one_cycle: got %b want 0", stall_o); end
    step();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 1; memwb_rd = 5'd2; memwb_result = 32'hCAFE;
    id_valid = 0;
    #1;
`else
    n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL exmem_dep_stall: got %b want 1", stall_o); end
    step();
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL exmem_dep_bubble: got %b want 0", ex_valid); end
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 1; memwb_rd = 5'd2; memwb_result = 32'hCAFE;
    id_rs_data = 32'hCAFE;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL memwb_no_stall: got %b want 0", stall_o); end
    step();
    idle_inputs();
    #1;
`endif
    n_cmp++; if (srcA !== 32'hCAFE || srcB !== 32'h3) begin n_err++; $display("FAIL load_use_srcA: got %h/%h want cafe/3", srcA, srcB); end
    n_cmp++; if (ex_valid !== 1'b1 || ex_rd !== 5'd5) begin n_err++; $display("FAIL load_use_add_ctrl: got v=%b rd=%0d want 1/5", ex_valid, ex_rd); end
    idle_inputs();
    step();
  endtask

  task automatic test_flush_hazard();
    drive_instr(5'd1, 5'd0, 5'd2, 1, 0, 32'h100, 32'h0, 32'h0, 1, 4'd0, 4'b1101);
    step();
    drive_instr(5'd2, 5'd1, 5'd5, 1, 1, 32'h5, 32'h3, 32'h0, 0, 4'd3, 4'b1000);
    flush_i = 1;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL flush_hazard_stall: got %b want 0", stall_o); end
    step();
    n_cmp++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ALUCtrl !== 4'd0) begin n_err++; $display("FAIL flush_bubble: got v=%b rw=%b alu=%h want 0/0/0", ex_valid, ex_reg_write, ALUCtrl); end
    idle_inputs();
  endtask

  task automatic test_hold();
    drive_instr(5'd10, 5'd11, 5'd6, 1, 1, 32'h11, 32'h22, 32'h0, 0, 4'd2, 4'b1010);
    step();
    drive_instr(5'd12, 5'd13, 5'd7, 1, 1, 32'h33, 32'h44, 32'h0, 0, 4'd3, 4'b1000);
    hold_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL hold_stall[%0d]: got %b want 1", i, stall_o); end
      step();
      n_cmp++; if (srcA !== 32'h11 || srcB !== 32'h22 || ALUCtrl !== 4'd2 || ex_rd !== 5'd6 || ex_valid !== 1'b1 || ex_mem_write !== 1'b1) begin
        n_err++; $display("FAIL hold_stable[%0d]: got %h/%h/%h rd=%0d v=%b mw=%b want 11/22/2 rd=6 v=1 mw=1", i, srcA, srcB, ALUCtrl, ex_rd, ex_valid, ex_mem_write);
      end
    end
    hold_i = 0;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL hold_release_stall: got %b want 0", stall_o); end
    step();
    n_cmp++; if (srcA !== 32'h33 || srcB !== 32'h44 || ALUCtrl !== 4'd3 || ex_rd !== 5'd7) begin n_err++; $display("FAIL hold_release_load: got %h/%h/%h rd=%0d want 33/44/3 rd=7", srcA, srcB, ALUCtrl, ex_rd); end
    hold_i = 1; flush_i = 1;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL flush_hold_stall: got %b want 0", stall_o); end
    step();
    n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_over_hold: got %b want 0", ex_valid); end
    idle_inputs();
  endtask

  task automatic test_dep_hazard();
    logic exp;
    // add $7 in ID/EX (no load); decode reads $7 through rt
    drive_instr(5'd1, 5'd2, 5'd7, 1, 1, 32'h1, 32'h2, 32'h0, 0, 4'd0, 4'b1000);
    step();
    drive_instr(5'd3, 5'd7, 5'd8, 1, 1, 32'h0, 32'h0, 32'h0, 0, 4'd0, 4'b1000);
    #1; exp = !FWD;
    n_cmp++; if (stall_o !== exp) begin n_err++; $display("FAIL alu_dep_stall: got %b want %b", stall_o, exp); end
    id_use_rt = 0;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL unused_src_no_stall: got %b want 0", stall_o); end
    id_use_rt = 1; id_valid = 0;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL invalid_slot_no_stall: got %b want 0", stall_o); end
    idle_inputs();
    // lw $0 never creates a dependency
    drive_instr(5'd1, 5'd0, 5'd0, 1, 0, 32'h0, 32'h0, 32'h0, 1, 4'd0, 4'b1101);
    step();
    drive_instr(5'd0, 5'd0, 5'd9, 1, 1, 32'h0, 32'h0, 32'h0, 0, 4'd0, 4'b1000);
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL reg0_no_stall: got %b want 0", stall_o); end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_exmem_fwd();
    test_dual_match();
    test_load_use();
    test_flush_hazard();
    test_hold();
    test_dep_hazard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
